// File: rtl/eth_miim_pkg.sv
// Shared definitions for the clause-22 MIIM responder: opcodes, field widths,
// bit-count terminals and the frame FSM state type.
package eth_miim_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned SKIP_BITS = TA_BITS + DATA_W;
  localparam int unsigned PRE_CNT_W = 6;
  localparam int unsigned BIT_CNT_W = 5;

  localparam logic [BIT_CNT_W-1:0] CNT_ADDR_LAST = BIT_CNT_W'(ADDR_W - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_DATA_DONE = BIT_CNT_W'(DATA_W);
  localparam logic [BIT_CNT_W-1:0] CNT_SKIP_LAST = BIT_CNT_W'(SKIP_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RDATA,
    S_WDATA,
    S_SKIP
  } miim_state_e;

endpackage

// File: rtl/eth_miim_responder_if.sv
// Management-side bundle of the MIIM responder: serial MDIO pins plus the
// register strobe/data bus and frame status.
interface eth_miim_responder_if;
  import eth_miim_pkg::*;

  logic              Mdc;
  logic              Mdi;
  logic              Mdo;
  logic              MdoEn;
  logic [ADDR_W-1:0] RegAddr;
  logic              RegRd;
  logic [DATA_W-1:0] RegRdData;
  logic              RegWr;
  logic [DATA_W-1:0] RegWrData;
  logic              Busy;
  logic              FrameErr;

  modport master (
    output Mdc, Mdi, RegRdData,
    input  Mdo, MdoEn, RegAddr, RegRd, RegWr, RegWrData, Busy, FrameErr
  );

  modport slave (
    input  Mdc, Mdi, RegRdData,
    output Mdo, MdoEn, RegAddr, RegRd, RegWr, RegWrData, Busy, FrameErr
  );

endinterface

// File: rtl/eth_miim_edge_sync.sv
// Synchronises Mdc and Mdi through one shared flop chain so they stay aligned,
// then flags Mdc rising/falling edges alongside the matching Mdi sample.
module eth_miim_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  input  logic mdi_i,
  output logic mdc_rise_o,
  output logic mdc_fall_o,
  output logic mdi_o
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic                        mdc_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      mdc_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], mdc_i, mdi_i};
      mdc_prev_q <= sync_q[SYNC_STAGES-1][1];
    end
  end

  assign mdc_rise_o =  sync_q[SYNC_STAGES-1][1] & ~mdc_prev_q;
  assign mdc_fall_o = ~sync_q[SYNC_STAGES-1][1] &  mdc_prev_q;
  assign mdi_o      =  sync_q[SYNC_STAGES-1][0];

endmodule

// File: rtl/eth_miim_responder.sv
// Clause-22 MIIM responder: decodes oversampled MDIO frames into register
// read/write strobes. Define ETH_MIIM_RESP_BCAST_EN to accept PHYAD=0 writes.
module eth_miim_responder
  import eth_miim_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRE_MIN     = 32
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [ADDR_W-1:0]   PhyAddr,
  eth_miim_responder_if.slave miim
);

  logic mdc_rise;
  logic mdc_fall;
  logic mdi_s;

  miim_state_e            state_q,    state_d;
  logic [PRE_CNT_W-1:0]   pre_q,      pre_d;
  logic [BIT_CNT_W-1:0]   cnt_q,      cnt_d;
  logic [DATA_W-1:0]      sh_q,       sh_d;
  logic [DATA_W-1:0]      rd_data_q,  rd_data_d;
  logic [DATA_W-1:0]      wr_data_q,  wr_data_d;
  logic [ADDR_W-1:0]      phyad_q,    phyad_d;
  logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
  logic                   op_rd_q,    op_rd_d;
  logic                   rd_q,       rd_d;
  logic                   wr_pend_q,  wr_pend_d;
  logic                   wr_q,       wr_d;
  logic                   mdo_q,      mdo_d;
  logic                   mdoen_q,    mdoen_d;
  logic                   busy_q,     busy_d;
  logic                   ferr_q,     ferr_d;

  logic                   addr_ok;
  logic [DATA_W-1:0]      sh_in;

  eth_miim_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .mdc_i      (miim.Mdc),
    .mdi_i      (miim.Mdi),
    .mdc_rise_o (mdc_rise),
    .mdc_fall_o (mdc_fall),
    .mdi_o      (mdi_s)
  );

  assign sh_in = {sh_q[DATA_W-2:0], mdi_s};

  always_comb begin
`ifdef ETH_MIIM_RESP_BCAST_EN
    if (op_rd_q) begin
      addr_ok = (phyad_q == PhyAddr) && (phyad_q != '0);
    end else begin
      addr_ok = (phyad_q == PhyAddr) || (phyad_q == '0);
    end
`else
    addr_ok = (phyad_q == PhyAddr);
`endif
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rd_data_d  = rd_q ? miim.RegRdData : rd_data_q;
    wr_data_d  = wr_data_q;
    phyad_d    = phyad_q;
    reg_addr_d = reg_addr_q;
    op_rd_d    = op_rd_q;
    rd_d       = 1'b0;
    wr_pend_d  = 1'b0;
    wr_d       = wr_pend_q;
    mdo_d      = mdo_q;
    mdoen_d    = mdoen_q;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: if (mdc_rise) begin
        if (mdi_s) begin
          if (pre_q != '1) pre_d = pre_q + 1'b1;
        end else begin
          pre_d = '0;
          if (32'(pre_q) >= PRE_MIN) state_d = S_ST;
        end
      end
      S_ST: if (mdc_rise) begin
        cnt_d = '0;
        if (mdi_s) begin
          state_d = S_OP;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OP: if (mdc_rise) begin
        sh_d = sh_in;
        if (cnt_q == '0) begin
          cnt_d = 1'b1;
        end else begin
          cnt_d = '0;
          if (sh_in[1:0] == OP_READ || sh_in[1:0] == OP_WRITE) begin
            op_rd_d = (sh_in[1:0] == OP_READ);
            state_d = S_PHYAD;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PHYAD: if (mdc_rise) begin
        sh_d  = sh_in;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_ADDR_LAST) begin
          phyad_d = sh_in[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = S_REGAD;
        end
      end
      S_REGAD: if (mdc_rise) begin
        sh_d  = sh_in;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_ADDR_LAST) begin
          reg_addr_d = sh_in[ADDR_W-1:0];
          cnt_d      = '0;
          if (addr_ok) begin
            rd_d    = op_rd_q;
            state_d = S_TA;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_TA: begin
        // Read turnaround and data advance on Mdc falls, where Mdo changes;
        // write turnaround is checked on rises like every other field.
        if (op_rd_q) begin
          if (mdc_fall) begin
            if (cnt_q == '0) begin
              cnt_d = 1'b1;
            end else begin
              mdoen_d = 1'b1;
              mdo_d   = 1'b0;
              sh_d    = rd_data_q;
              cnt_d   = '0;
              state_d = S_RDATA;
            end
          end
        end else if (mdc_rise) begin
          if (cnt_q == '0) begin
            cnt_d = 1'b1;
            if (!mdi_s) begin
              ferr_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = '0;
            if (mdi_s) begin
              ferr_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
      end
      S_RDATA: if (mdc_fall) begin
        if (cnt_q == CNT_DATA_DONE) begin
          mdoen_d = 1'b0;
          mdo_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          mdo_d = sh_q[DATA_W-1];
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WDATA: if (mdc_rise) begin
        sh_d  = sh_in;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_DATA_LAST) begin
          wr_data_d = sh_in;
          wr_pend_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_SKIP: if (mdc_rise) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_SKIP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      rd_data_q  <= '0;
      wr_data_q  <= '0;
      phyad_q    <= '0;
      reg_addr_q <= '0;
      op_rd_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_q       <= 1'b0;
      mdo_q      <= 1'b0;
      mdoen_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rd_data_q  <= rd_data_d;
      wr_data_q  <= wr_data_d;
      phyad_q    <= phyad_d;
      reg_addr_q <= reg_addr_d;
      op_rd_q    <= op_rd_d;
      rd_q       <= rd_d;
      wr_pend_q  <= wr_pend_d;
      wr_q       <= wr_d;
      mdo_q      <= mdo_d;
      mdoen_q    <= mdoen_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

  assign miim.Mdo       = mdo_q;
  assign miim.MdoEn     = mdoen_q;
  assign miim.RegAddr   = reg_addr_q;
  assign miim.RegRd     = rd_q;
  assign miim.RegWr     = wr_q;
  assign miim.RegWrData = wr_data_q;
  assign miim.Busy      = busy_q;
  assign miim.FrameErr  = ferr_q;

endmodule
